frog_score_keeper: RTL and testbench
====================================

# frog_score_keeper

Multi-digit, parametrised score and lives tracker for the Frogger game. Sits between the frog/collision logic and the HEX displays. It detects each rising edge of the frog reaching the top row or dying, then updates:
- a saturating multi-digit BCD score,
- a level counter,
- a lives counter.

It emits one-cycle pulses that restart the frog mid-game. It drives one active-low seven-segment pattern per score digit.

## Interface
- DIGITS, 2: number of BCD score digits (1–4).
- LIVES, 3: starting lives (1–7).
- LEVEL_STEP, 5: points per level-up (1–15).
- clk  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-high; clock clk.
- frog_reached_top  input  1  level; high while frog occupies top row.
- frog_died  input  1  level; high while frog is in a collision.
- mid_reset  output  1  one-cycle pulse; restart frog position.
- level_up  output  1  one-cycle pulse coincident with mid_reset when level increments.
- game_over  output  1  high once lives reach 0; held until reset.
- score_bcd  output  4*DIGITS  packed BCD score; digit 0 in bits [3:0].
- score_seg  output  7*DIGITS  active-low segments; digit i in bits [7i+6:7i].
- level  output  4  current level, starts at 0.
- lives  output  3  remaining lives.

## Operation
- Inputs are registered once; prev copies are kept for edge detection.
  - reach_edge = top_q & ~top_prev
  - die_edge = died_q & ~died_prev
- FSM states: IDLE, SCORE, DEAD, WAIT_LOW, GAME_OVER.
- IDLE transitions:
  - die_edge → DEAD.
  - Otherwise, reach_edge → SCORE.
  - Simultaneous edges: death wins, no score.
- SCORE (exactly 1 cycle):
  - Score increments on entry: BCD add with ripple carry across digits.
  - At all-9s (e.g. 99 for DIGITS=2), score saturates and does not wrap.
  - A binary step counter (0..LEVEL_STEP-1) increments, but only if the score actually changed.
  - On step counter wrap to 0: level increments (saturates at 15) and level_up asserts.
  - Next state: WAIT_LOW.
- DEAD (exactly 1 cycle):
  - lives decrements on entry.
  - Next state: GAME_OVER if lives now 0, else WAIT_LOW.
- WAIT_LOW: stay until top_q and died_q are both low, then IDLE. This stops a held input from re-triggering.
- GAME_OVER: absorbing until reset. Edges are ignored; score, level and lives freeze.
- mid_reset = (state==SCORE) | (state==DEAD), decoded from registered state.
- Reset values:
  - state IDLE; score 0 (all digits); step counter 0; level 0; lives = LIVES.
  - Input regs 0; mid_reset 0; level_up 0; game_over 0.
  - score_seg shows "0" on every digit (7'b1000000 per digit).
- Reset asserted mid-operation (any state, including SCORE/DEAD): all registers return to reset values immediately. No pulse completes.

## Timing
- Input sampled high in cycle N (prev low): input reg high at N+1, state SCORE/DEAD at N+2.
- mid_reset, level_up, updated score_bcd and lives are all visible in cycle N+2. Total latency is 2 clocks.
- mid_reset width is exactly 1 clock per event.
- Minimum event spacing: the input must be low for at least 1 sampled cycle between events.
- score_seg is combinational from score_bcd; it has no additional latency.
- game_over rises in the cycle after DEAD, together with state GAME_OVER.

## Configuration
- HIGH_SCORE_EN defined:
  - Adds output high_score_bcd (4*DIGITS).
  - high_score_bcd updates to score in the cycle after any score change that exceeds it.
  - high_score_bcd is cleared only by reset.
- HIGH_SCORE_EN undefined: no high_score_bcd port and no register; all other behaviour identical.

## Structure
- Package frogger_pkg holds:
  - the state_t typedef (IDLE, SCORE, DEAD, WAIT_LOW, GAME_OVER);
  - the BCD digit type;
  - constant SEG_ZERO = 7'b1000000.
- Per-digit display uses the existing seg7 sub-module (ports bcd, inverse), instantiated DIGITS times in a generate loop.
- The BCD increment/saturate is a function in frogger_pkg. It is not a separate module.

## Test plan
- Reset with DIGITS=2, LIVES=3. Expect:
  - score_bcd=8'h00, lives=3, level=0, game_over=0, mid_reset=0;
  - score_seg = {7'b1000000, 7'b1000000}.
- frog_reached_top high for 10 cycles:
  - exactly one mid_reset pulse, 2 clocks after the first sample;
  - score_bcd=8'h01.
- 10 reach events, LEVEL_STEP=5:
  - score 8'h10 (BCD carry 09→10);
  - level_up pulses at scores 05 and 10;
  - level=2.
- Preload via 99 events:
  - score saturates at 8'h99;
  - 100th event still pulses mid_reset, score remains 8'h99, no level_up.
- frog_reached_top and frog_died rise in the same cycle:
  - lives 3→2, score unchanged, one mid_reset.
  - Two more deaths → game_over=1; subsequent events produce no mid_reset.
- Reset asserted during SCORE cycle: mid_reset drops immediately, score=0, lives=3. With HIGH_SCORE_EN, high_score_bcd=0.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types and helpers for the frogger score keeper.
// State encoding, BCD digit type, seven-segment constant.
package frogger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCORE,
    DEAD,
    WAIT_LOW,
    GAME_OVER
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  // One ripple stage of a BCD increment: returns {carry_out, digit}.
  function automatic logic [4:0] bcd_step(
    input bcd_t d,
    input logic cin
  );
    if (!cin)
      return {1'b0, d};
    if (d == 4'd9)
      return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/seg7.sv
// BCD digit to active-low seven-segment pattern (bit 6 = g).
// Non-decimal codes blank the digit.
module seg7
  import frogger_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] inverse
);

  always_comb begin
    inverse = 7'b1111111;
    unique case (bcd)
      4'd0:    inverse = SEG_ZERO;
      4'd1:    inverse = 7'b1111001;
      4'd2:    inverse = 7'b0100100;
      4'd3:    inverse = 7'b0110000;
      4'd4:    inverse = 7'b0011001;
      4'd5:    inverse = 7'b0010010;
      4'd6:    inverse = 7'b0000010;
      4'd7:    inverse = 7'b1111000;
      4'd8:    inverse = 7'b0000000;
      4'd9:    inverse = 7'b0010000;
      default: inverse = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/frog_score_keeper.sv
// Frogger score, level and lives tracker with HEX display drive.
// Optional HIGH_SCORE_EN adds a high_score_bcd output.
module frog_score_keeper
  import frogger_pkg::*;
#(
  parameter int DIGITS     = 2,
  parameter int LIVES      = 3,
  parameter int LEVEL_STEP = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frog_reached_top,
  input  logic                  frog_died,
  output logic                  mid_reset,
  output logic                  level_up,
  output logic                  game_over,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [7*DIGITS-1:0]   score_seg,
  output logic [3:0]            level,
`ifdef HIGH_SCORE_EN
  output logic [4*DIGITS-1:0]   high_score_bcd,
`endif
  output logic [2:0]            lives
);

  localparam logic [3:0] STEP_MAX = 4'(LEVEL_STEP - 1);

  state_t              state;
  logic                top_q;
  logic                died_q;
  logic                top_prev;
  logic                died_prev;
  logic                reach_edge;
  logic                die_edge;
  logic [4*DIGITS-1:0] score_q;
  logic [4*DIGITS-1:0] score_inc;
  logic                sat;
  logic [3:0]          step_q;

  assign reach_edge = top_q & ~top_prev;
  assign die_edge   = died_q & ~died_prev;

  // Carry out of the top digit means every digit was 9.
  always_comb begin
    logic c;
    c = 1'b1;
    score_inc = '0;
    for (int i = 0; i < DIGITS; i++) begin
      {c, score_inc[4*i +: 4]} = bcd_step(score_q[4*i +: 4], c);
    end
    sat = c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      top_q     <= 1'b0;
      died_q    <= 1'b0;
      top_prev  <= 1'b0;
      died_prev <= 1'b0;
      score_q   <= '0;
      step_q    <= '0;
      level     <= '0;
      lives     <= 3'(LIVES);
      level_up  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      top_q     <= frog_reached_top;
      died_q    <= frog_died;
      top_prev  <= top_q;
      died_prev <= died_q;
      level_up  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (die_edge) begin
            state <= DEAD;
            lives <= lives - 3'd1;
          end else if (reach_edge) begin
            state <= SCORE;
            if (!sat) begin
              score_q <= score_inc;
              if (step_q == STEP_MAX) begin
                step_q   <= '0;
                level_up <= 1'b1;
                if (level != 4'd15)
                  level <= level + 4'd1;
              end else begin
                step_q <= step_q + 4'd1;
              end
            end
          end
        end
        SCORE:
          state <= WAIT_LOW;
        DEAD: begin
          if (lives == 3'd0) begin
            state     <= GAME_OVER;
            game_over <= 1'b1;
          end else begin
            state <= WAIT_LOW;
          end
        end
        WAIT_LOW:
          if (!top_q && !died_q)
            state <= IDLE;
        GAME_OVER:
          state <= GAME_OVER;
        default:
          state <= IDLE;
      endcase
    end
  end

  assign mid_reset = (state == SCORE) | (state == DEAD);
  assign score_bcd = score_q;

`ifdef HIGH_SCORE_EN
  // Packed BCD orders the same as its numeric value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      high_score_bcd <= '0;
    else if (score_q > high_score_bcd)
      high_score_bcd <= score_q;
  end
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    seg7 u_seg (
      .bcd     (score_q[4*i +: 4]),
      .inverse (score_seg[7*i +: 7])
    );
  end

endmodule

// File: tb/tb_frog_score_keeper.sv
// Directed testbench for frog_score_keeper (DIGITS=2, LIVES=3,
// LEVEL_STEP=5).
module tb_frog_score_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        frog_reached_top;
  logic        frog_died;
  logic        mid_reset;
  logic        level_up;
  logic        game_over;
  logic [7:0]  score_bcd;
  logic [13:0] score_seg;
  logic [3:0]  level;
  logic [2:0]  lives;
`ifdef HIGH_SCORE_EN
  logic [7:0]  high_score_bcd;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frog_score_keeper #(
    .DIGITS     (2),
    .LIVES      (3),
    .LEVEL_STEP (5)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .frog_reached_top (frog_reached_top),
    .frog_died        (frog_died),
    .mid_reset        (mid_reset),
    .level_up         (level_up),
    .game_over        (game_over),
    .score_bcd        (score_bcd),
    .score_seg        (score_seg),
    .level            (level),
`ifdef HIGH_SCORE_EN
    .high_score_bcd   (high_score_bcd),
`endif
    .lives            (lives)
  );

  task automatic do_reset();
    reset = 1'b1;
    frog_reached_top = 1'b0;
    frog_died = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Hold inputs for 'hold' cycles, then low long enough to re-arm.
  task automatic pulse(input logic t, input logic d, input int hold,
                       output int mr, output int lu);
    mr = 0;
    lu = 0;
    frog_reached_top = t;
    frog_died = d;
    for (int i = 0; i < hold + 6; i++) begin
      if (i == hold) begin
        frog_reached_top = 1'b0;
        frog_died = 1'b0;
      end
      @(negedge clk);
      mr += int'(mid_reset);
      lu += int'(level_up);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    frog_reached_top = 1'b0;
    frog_died = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (score_bcd !== 8'h00) begin
      errors++; $display("FAIL reset_score got %h want 00", score_bcd);
    end
    checks++;
    if (lives !== 3'd3) begin
      errors++; $display("FAIL reset_lives got %0d want 3", lives);
    end
    checks++;
    if (level !== 4'd0) begin
      errors++; $display("FAIL reset_level got %0d want 0", level);
    end
    checks++;
    if (game_over !== 1'b0) begin
      errors++; $display("FAIL reset_game_over got %b want 0", game_over);
    end
    checks++;
    if (mid_reset !== 1'b0) begin
      errors++; $display("FAIL reset_mid_reset got %b want 0", mid_reset);
    end
    checks++;
    if (score_seg !== {7'b1000000, 7'b1000000}) begin
      errors++; $display("FAIL reset_seg got %b want 10000001000000", score_seg);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold();
    int mr;
    do_reset();
    frog_reached_top = 1'b1;
    @(negedge clk);
    checks++;
    if (mid_reset !== 1'b0) begin
      errors++; $display("FAIL hold_early got %b want 0", mid_reset);
    end
    @(negedge clk);
    checks++;
    if (mid_reset !== 1'b1 || score_bcd !== 8'h01) begin
      errors++;
      $display("FAIL hold_latency got mr=%b score=%h want mr=1 score=01",
               mid_reset, score_bcd);
    end
    mr = 1;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) frog_reached_top = 1'b0;
      @(negedge clk);
      mr += int'(mid_reset);
    end
    checks++;
    if (mr != 1 || score_bcd !== 8'h01) begin
      errors++;
      $display("FAIL hold_single got pulses=%0d score=%h want 1 01",
               mr, score_bcd);
    end
  endtask

  task automatic test_levels();
    int mr, lu;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      pulse(1'b1, 1'b0, 2, mr, lu);
      checks++;
      if (mr != 1 || lu != ((k % 5 == 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL level_event%0d got mr=%0d lu=%0d want mr=1 lu=%0d",
                 k, mr, lu, (k % 5 == 0) ? 1 : 0);
      end
    end
    checks++;
    if (score_bcd !== 8'h10 || level !== 4'd2) begin
      errors++;
      $display("FAIL level_final got score=%h level=%0d want 10 2",
               score_bcd, level);
    end
    checks++;
    if (score_seg !== {7'b1111001, 7'b1000000}) begin
      errors++;
      $display("FAIL level_seg got %b want 11110011000000", score_seg);
    end
  endtask

  task automatic test_saturate();
    int mr, lu;
    do_reset();
    for (int k = 0; k < 99; k++)
      pulse(1'b1, 1'b0, 1, mr, lu);
    checks++;
    if (score_bcd !== 8'h99 || level !== 4'd15) begin
      errors++;
      $display("FAIL sat_99 got score=%h level=%0d want 99 15",
               score_bcd, level);
    end
`ifdef HIGH_SCORE_EN
    checks++;
    if (high_score_bcd !== 8'h99) begin
      errors++; $display("FAIL sat_high got %h want 99", high_score_bcd);
    end
`endif
    pulse(1'b1, 1'b0, 1, mr, lu);
    checks++;
    if (mr != 1 || lu != 0 || score_bcd !== 8'h99) begin
      errors++;
      $display("FAIL sat_100 got mr=%0d lu=%0d score=%h want 1 0 99",
               mr, lu, score_bcd);
    end
  endtask

  task automatic test_death();
    int mr, lu;
    do_reset();
    pulse(1'b1, 1'b0, 1, mr, lu);
    pulse(1'b1, 1'b1, 1, mr, lu);
    checks++;
    if (mr != 1 || lives !== 3'd2 || score_bcd !== 8'h01) begin
      errors++;
      $display("FAIL death_both got mr=%0d lives=%0d score=%h want 1 2 01",
               mr, lives, score_bcd);
    end
    pulse(1'b0, 1'b1, 1, mr, lu);
    checks++;
    if (mr != 1 || lives !== 3'd1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL death_second got mr=%0d lives=%0d go=%b want 1 1 0",
               mr, lives, game_over);
    end
    pulse(1'b0, 1'b1, 1, mr, lu);
    checks++;
    if (mr != 1 || lives !== 3'd0 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL death_third got mr=%0d lives=%0d go=%b want 1 0 1",
               mr, lives, game_over);
    end
    pulse(1'b1, 1'b0, 1, mr, lu);
    checks++;
    if (mr != 0 || score_bcd !== 8'h01) begin
      errors++;
      $display("FAIL over_reach got mr=%0d score=%h want 0 01",
               mr, score_bcd);
    end
    pulse(1'b0, 1'b1, 1, mr, lu);
    checks++;
    if (mr != 0 || lives !== 3'd0 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL over_die got mr=%0d lives=%0d go=%b want 0 0 1",
               mr, lives, game_over);
    end
  endtask

  task automatic test_reset_mid_score();
    do_reset();
    frog_reached_top = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (mid_reset !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got %b want 1", mid_reset);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mid_reset !== 1'b0 || score_bcd !== 8'h00 || lives !== 3'd3) begin
      errors++;
      $display("FAIL midrst_async got mr=%b score=%h lives=%0d want 0 00 3",
               mid_reset, score_bcd, lives);
    end
`ifdef HIGH_SCORE_EN
    checks++;
    if (high_score_bcd !== 8'h00) begin
      errors++; $display("FAIL midrst_high got %h want 00", high_score_bcd);
    end
`endif
    frog_reached_top = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_hold();
    test_levels();
    test_saturate();
    test_death();
    test_reset_mid_score();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
